// File: rtl/z80_im2_intc_pkg.sv
// rtl/z80_im2_intc_pkg.sv - shared constants and FSM state type for the IM2 interrupt controller
package z80_intc_pkg;

    localparam int NSRC_MAX = 8;
    localparam int IDX_W    = $clog2(NSRC_MAX);

    // Register offsets within the 4-port block at BASE_PORT
    localparam logic [1:0] OFS_MASK  = 2'd0;
    localparam logic [1:0] OFS_PEND  = 2'd1;
    localparam logic [1:0] OFS_VBASE = 2'd2;
    localparam logic [1:0] OFS_ISR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        END  = 2'd2
    } state_t;

endpackage

// File: rtl/z80_im2_intc_if.sv
// rtl/z80_im2_intc_if.sv - Z80 I/O bus bundle between CPU side (master) and interrupt controller (slave)
// Signals: A address, D_in CPU write data, D_out/D_oe controller read/vector data,
//          nIORQ/nM1/nRD/nWR Z80 control strobes.
interface z80_im2_intc_if;
    logic [7:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       nIORQ;
    logic       nM1;
    logic       nRD;
    logic       nWR;

    modport master (output A, D_in, nIORQ, nM1, nRD, nWR, input D_out, D_oe);
    modport slave  (input A, D_in, nIORQ, nM1, nRD, nWR, output D_out, D_oe);
endinterface

// File: rtl/z80_im2_intc_prio_enc.sv
// rtl/z80_im2_intc_prio_enc.sv - lowest-index-first priority encoder
// Ports: req_i request vector, idx_o index of lowest set bit, valid_o any bit set.
module intc_prio_enc
    import z80_intc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]  req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/z80_im2_intc.sv
// rtl/z80_im2_intc.sv - Z80 mode-2 vectored interrupt controller (up to 8 sources, fixed priority)
// Ports: CLK50MHz clock, nRESET sync active-low reset, CPUCLK0 write qualifier strobe,
//        irq_in async active-high requests, nint_oe pull-nINT-low request, bus Z80 I/O bundle.
// Build option: INTC_EDGE_EN selects edge-latched PEND (default: level-following PEND).
module z80_im2_intc
    import z80_intc_pkg::*;
#(
    parameter int          NSRC      = 8,
    parameter logic [7:0]  BASE_PORT = 8'hC0
) (
    input  logic            CLK50MHz,
    input  logic            nRESET,
    input  logic            CPUCLK0,
    input  logic [NSRC-1:0] irq_in,
    output logic            nint_oe,
    z80_im2_intc_if.slave   bus
);

    state_t state_q, state_d;
    logic [NSRC-1:0]  sync1_q, sync2_q;
    logic [NSRC-1:0]  mask_q, mask_d, pend_q, pend_d, isr_q, isr_d;
    logic [NSRC-1:0]  thr, elig;
    logic [7:0]       vbase_q, vbase_d, vector, rdata;
    logic [IDX_W-1:0] id_q, id_d, elig_idx, isr_idx;
    logic             spur_q, spur_d, nint_q, nint_d, wr_done_q;
    logic             elig_vld, isr_vld, capture;
    logic             hit, intack, io_cyc, rd_en, wr_cyc, wr_en;
    logic [1:0]       ofs;

    assign hit    = (bus.A[7:2] == BASE_PORT[7:2]);
    assign ofs    = bus.A[1:0];
    assign intack = !bus.nM1 && !bus.nIORQ;
    assign io_cyc = !bus.nIORQ && bus.nM1 && hit;
    assign rd_en  = io_cyc && !bus.nRD;
    assign wr_cyc = io_cyc && !bus.nWR;
    // A Z80 write spans several CPUCLK0 strobes; act only on the first so EOI clears one bit.
    assign wr_en  = wr_cyc && CPUCLK0 && !wr_done_q;

    // Only sources of strictly higher priority than the current in-service level may nest.
    always_comb begin
        thr = '0;
        for (int i = 0; i < NSRC; i++) begin
            thr[i] = !isr_vld || (IDX_W'(i) < isr_idx);
        end
    end
    assign elig = pend_q & mask_q & thr;

    intc_prio_enc #(.NSRC(NSRC)) u_elig_enc (.req_i(elig),  .idx_o(elig_idx), .valid_o(elig_vld));
    intc_prio_enc #(.NSRC(NSRC)) u_isr_enc  (.req_i(isr_q), .idx_o(isr_idx),  .valid_o(isr_vld));

`ifdef INTC_EDGE_EN
    logic [NSRC-1:0] hist_q, rise_q;
    // Registered edge detect keeps edge-mode PEND one cycle behind the level-mode path.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            hist_q <= '0;
            rise_q <= '0;
        end else begin
            hist_q <= sync2_q;
            rise_q <= sync2_q & ~hist_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        spur_d  = spur_q;
        mask_d  = mask_q;
        vbase_d = vbase_q;
        isr_d   = isr_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (intack) begin
                state_d = ACK;
                capture = 1'b1;
                id_d    = elig_idx;
                spur_d  = !elig_vld;
            end
            ACK:     state_d = END;
            END:     if (!intack) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_en && ofs == OFS_MASK)  mask_d  = bus.D_in[NSRC-1:0];
        if (wr_en && ofs == OFS_VBASE) vbase_d = {bus.D_in[7:1], 1'b0};

        // EOI clear first, then the acknowledge set, so a same-cycle pair nets both effects.
        for (int i = 0; i < NSRC; i++) begin
            if (wr_en && ofs == OFS_ISR && isr_vld && IDX_W'(i) == isr_idx) isr_d[i] = 1'b0;
            if (capture && elig_vld && IDX_W'(i) == elig_idx)                isr_d[i] = 1'b1;
        end

`ifdef INTC_EDGE_EN
        pend_d = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (wr_en && ofs == OFS_PEND && bus.D_in[i])       pend_d[i] = 1'b0;
            if (capture && elig_vld && IDX_W'(i) == elig_idx) pend_d[i] = 1'b0;
        end
        pend_d = pend_d | rise_q;
`else
        pend_d = sync2_q;
`endif

        nint_d = (state_d == IDLE) && elig_vld;
    end

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
            vbase_q   <= '0;
            id_q      <= '0;
            spur_q    <= 1'b0;
            nint_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            vbase_q   <= vbase_d;
            id_q      <= id_d;
            spur_q    <= spur_d;
            nint_q    <= nint_d;
            wr_done_q <= wr_cyc && (wr_done_q || wr_en);
        end
    end

    // Spurious acks return the slot just past the last source.
    assign vector = spur_q ? (vbase_q + 8'(2 * NSRC))
                           : (vbase_q + {{(7 - IDX_W){1'b0}}, id_q, 1'b0});

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_MASK:  rdata = 8'(mask_q);
            OFS_PEND:  rdata = 8'(pend_q);
            OFS_VBASE: rdata = vbase_q;
            OFS_ISR:   rdata = 8'(isr_q);
            default:   rdata = '0;
        endcase
    end

    // Vector drive starts once the ack has been captured so id_q is stable.
    assign bus.D_oe  = rd_en || (intack && state_q != IDLE);
    assign bus.D_out = intack ? vector : rdata;
    assign nint_oe   = nint_q;

endmodule
